mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Load/store sequencer directly upstream of the data memory.
- Takes one byte or 16-bit halfword request per handshake from the datapath.
- Drives the memory's address, MemStatus and write-data pins one byte per cycle: halfwords take two accesses, little-endian.
- Captures the memory's combinational read data into a 16-bit result register and signals completion with a one-cycle Done pulse.

Parameters:
W, 8, address width; memory depth 2**W bytes; address arithmetic wraps modulo 2**W

Ports:
CLK  input  1  clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Req  input  1  request strobe from datapath; sampled only while Busy=0
Op  input  1  0=load, 1=store
Wide  input  1  0=byte access, 1=16-bit access (bytes at Addr and Addr+1)
Addr  input  W  byte address of low byte
WrData  input  16  store data; bits [7:0] go to Addr, bits [15:8] to Addr+1
Busy  output  1  high whenever state != IDLE
Done  output  1  one-cycle pulse, operation complete
RdData  output  16  load result register
MemAddr  output  W  to memory DataAddress
MemStatus  output  2  to memory: 00 idle, 01 load, 10 store; 11 never driven
MemWrData  output  8  to memory DataIn
MemRdData  input  8  from memory DataOut; high-Z unless MemStatus=01

Behaviour:
- Reset (async, immediate):
  - State=IDLE; Busy=0, Done=0, RdData=16'h0000.
  - MemStatus=00, MemAddr=0, MemWrData=0; internal latches cleared.
- States: IDLE, ACC0, ACC1, DONE.
- IDLE:
  - MemStatus=00, Busy=0.
  - On an edge with Req=1: latch Op, Wide, Addr, WrData; go to ACC0.
  - Req=0 keeps IDLE.
- ACC0:
  - MemAddr=latched Addr; MemStatus = 10 if Op=store, else 01; MemWrData=WrData[7:0].
  - At the closing edge, a store commits in memory. A load captures MemRdData into RdData[7:0]; for a byte load, RdData[15:8] is set to 0 (zero-extend).
  - Next state: ACC1 if Wide, else DONE.
- ACC1:
  - MemAddr=(Addr+1) mod 2**W, so Addr=2**W-1 wraps to 0; MemWrData=WrData[15:8]; MemStatus as in ACC0.
  - A load captures MemRdData into RdData[15:8] at the closing edge.
  - Next state: DONE.
- DONE:
  - MemStatus=00, Done=1, Busy=1; next state IDLE.
  - RdData is valid from DONE onward and holds until the next load's first capture.
- Outputs:
  - All memory-side outputs are decoded from registered state and latches, so they are glitch-free within the cycle.
  - MemAddr and MemWrData hold their last values when idle.
  - A store never modifies RdData.
- Latency, with Req sampled at edge E0:
  - Byte op: ACC0 in cycle E0–E1; Done high in cycle E1–E2.
  - Wide op: Done high in cycle E2–E3.
  - Back-to-back throughput is 1 request per 3 cycles (byte) or 4 cycles (wide); Req is accepted only in IDLE.
- Req while Busy=1 is ignored, not queued; the requester must hold or re-assert Req.
- Input changes on Op/Wide/Addr/WrData after acceptance have no effect on the operation in flight.
- Reset mid-operation:
  - Aborts immediately; MemStatus drops to 00 asynchronously.
  - A store whose access edge coincides with Reset assertion is not guaranteed; a store in ACC1 interrupted after the ACC0 edge leaves the low byte written and the high byte unwritten.
  - No Done pulse is produced for an aborted operation.
- MemStatus=11 must never appear; a bench assertion checks this every cycle.

Test Plan:
- Byte store then byte load:
  - Store Addr=8'h10, WrData=16'h00A5, Wide=0 → one cycle with MemStatus=10, MemAddr=10, MemWrData=A5; Done 2 cycles after Req edge.
  - Load Addr=8'h10 → RdData=16'h00A5.
- Wide store then wide load:
  - Store Addr=8'h20, WrData=16'hBEEF → M[20]=EF, M[21]=BE.
  - Wide load Addr=8'h20 → RdData=16'hBEEF, Done 3 cycles after Req edge.
- Wrap-around:
  - Wide store Addr=8'hFF, WrData=16'h1234 → M[FF]=34, M[00]=12.
  - Wide load Addr=8'hFF → RdData=16'h1234.
- Busy rejection:
  - Hold Req=1 continuously with changing Addr → exactly one accept per 3 (byte) or 4 (wide) cycles.
  - Inputs changed during ACC0 do not alter MemAddr/MemWrData of the in-flight access.
- Reset mid-wide-store:
  - Wide store Addr=8'h40, WrData=16'hCAFE; assert Reset during ACC1 → MemStatus=00 immediately, Busy=0, Done never pulses.
  - M[40]=FE, M[41] unchanged; RdData=0.
- Idle hygiene:
  - After Reset with no Req for 20 cycles → MemStatus=00, Done=0 throughout.
  - Byte load following a wide load clears RdData[15:8] to 00.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Byte/halfword load-store sequencer driving a byte-wide data memory.
// Revision : 1.0
// ============================================================================
module mem_access_ctrl #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Req,
    input  logic         Op,
    input  logic         Wide,
    input  logic [W-1:0] Addr,
    input  logic [15:0]  WrData,
    output logic         Busy,
    output logic         Done,
    output logic [15:0]  RdData,
    output logic [W-1:0] MemAddr,
    output logic [1:0]   MemStatus,
    output logic [7:0]   MemWrData,
    input  logic [7:0]   MemRdData
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] c_MS_IDLE  = 2'b00;
    localparam logic [1:0] c_MS_LOAD  = 2'b01;
    localparam logic [1:0] c_MS_STORE = 2'b10;

    state_t         r_state;
    state_t         w_next;
    logic           r_op;
    logic           r_wide;
    logic [7:0]     r_wrdata_hi;
    logic [15:0]    r_rddata;
    logic [W-1:0]   r_memaddr;
    logic [7:0]     r_memwrdata;
    logic [1:0]     w_memstatus;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_memstatus = c_MS_IDLE;
        case (r_state)
            S_IDLE: if (Req) w_next = S_ACC0;
            S_ACC0: begin
                w_memstatus = r_op ? c_MS_STORE : c_MS_LOAD;
                w_next      = r_wide ? S_ACC1 : S_DONE;
            end
            S_ACC1: begin
                w_memstatus = r_op ? c_MS_STORE : c_MS_LOAD;
                w_next      = S_DONE;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Memory-side address/data are loaded one edge ahead of each access so
    // they are stable registers for the whole access cycle.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_op        <= 1'b0;
            r_wide      <= 1'b0;
            r_wrdata_hi <= 8'h00;
            r_rddata    <= 16'h0000;
            r_memaddr   <= '0;
            r_memwrdata <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Req) begin
                        r_op        <= Op;
                        r_wide      <= Wide;
                        r_wrdata_hi <= WrData[15:8];
                        r_memaddr   <= Addr;
                        r_memwrdata <= WrData[7:0];
                    end
                end
                S_ACC0: begin
                    if (!r_op) begin
                        r_rddata[7:0] <= MemRdData;
                        if (!r_wide) begin
                            r_rddata[15:8] <= 8'h00;
                        end
                    end
                    if (r_wide) begin
                        r_memaddr   <= r_memaddr + {{(W-1){1'b0}}, 1'b1};
                        r_memwrdata <= r_wrdata_hi;
                    end
                end
                S_ACC1: begin
                    if (!r_op) begin
                        r_rddata[15:8] <= MemRdData;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy      = (r_state != S_IDLE);
    assign Done      = (r_state == S_DONE);
    assign RdData    = r_rddata;
    assign MemAddr   = r_memaddr;
    assign MemStatus = w_memstatus;
    assign MemWrData = r_memwrdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl with a byte memory and a
//            behavioural reference memory. Revision : 1.0
// ============================================================================
module tb_mem_access_ctrl;

    localparam int W = 8;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          Req;
    logic          Op;
    logic          Wide;
    logic [W-1:0]  Addr;
    logic [15:0]   WrData;
    logic          Busy;
    logic          Done;
    logic [15:0]   RdData;
    logic [W-1:0]  MemAddr;
    logic [1:0]    MemStatus;
    logic [7:0]    MemWrData;
    logic [7:0]    MemRdData;

    logic [7:0]    mem     [256];
    logic [7:0]    ref_mem [256];
    logic [15:0]   exp_rd;
    int            total = 0;
    int            bad   = 0;

    mem_access_ctrl #(.W(W)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Req       (Req),
        .Op        (Op),
        .Wide      (Wide),
        .Addr      (Addr),
        .WrData    (WrData),
        .Busy      (Busy),
        .Done      (Done),
        .RdData    (RdData),
        .MemAddr   (MemAddr),
        .MemStatus (MemStatus),
        .MemWrData (MemWrData),
        .MemRdData (MemRdData)
    );

    always #5 CLK = ~CLK;

    // Memory device: write on the edge closing a store cycle; read data is
    // only meaningful while MemStatus=01, otherwise garbage is presented.
    always @(posedge CLK) begin
        if (MemStatus == 2'b10) mem[MemAddr] <= MemWrData;
    end
    assign MemRdData = (MemStatus == 2'b01) ? mem[MemAddr] : ~mem[MemAddr];

    always @(negedge CLK) begin
        total++;
        if (MemStatus === 2'b11) begin
            bad++;
            $display("FAIL memstatus_11 got=%b required!=11", MemStatus);
        end
    end

    task automatic do_op(input bit op, input bit wide, input logic [7:0] a,
                         input logic [15:0] wd);
        int          n;
        bit          got;
        logic [7:0]  a1;
        a1 = a + 8'd1;
        @(negedge CLK);
        Req = 1'b1; Op = op; Wide = wide; Addr = a; WrData = wd;
        @(posedge CLK);
        #1;
        Req = 1'b0; Op = ~op; Wide = 1'($urandom); Addr = 8'($urandom); WrData = 16'($urandom);
        n = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                Addr = 8'($urandom); WrData = 16'($urandom); Wide = 1'($urandom);
                total++;
                if (MemStatus !== (op ? 2'b10 : 2'b01) || MemAddr !== a || MemWrData !== wd[7:0]) begin
                    bad++;
                    $display("FAIL acc0 got st=%b a=%h d=%h required st=%b a=%h d=%h",
                             MemStatus, MemAddr, MemWrData, op ? 2'b10 : 2'b01, a, wd[7:0]);
                end
            end
            if (n == 2 && wide) begin
                total++;
                if (MemStatus !== (op ? 2'b10 : 2'b01) || MemAddr !== a1 || MemWrData !== wd[15:8]) begin
                    bad++;
                    $display("FAIL acc1 got st=%b a=%h d=%h required st=%b a=%h d=%h",
                             MemStatus, MemAddr, MemWrData, op ? 2'b10 : 2'b01, a1, wd[15:8]);
                end
            end
            if (Done === 1'b1) got = 1'b1;
        end
        total++;
        if (!got || n != (wide ? 3 : 2)) begin
            bad++;
            $display("FAIL latency got=%0d required=%0d", got ? n : -1, wide ? 3 : 2);
        end
        if (op) begin
            ref_mem[a] = wd[7:0];
            if (wide) ref_mem[a1] = wd[15:8];
        end else begin
            exp_rd = wide ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
        end
        total++;
        if (RdData !== exp_rd) begin
            bad++;
            $display("FAIL rddata op=%0d wide=%0d addr=%h got=%h required=%h", op, wide, a, RdData, exp_rd);
        end
        @(negedge CLK);
        total++;
        if (Done !== 1'b0 || Busy !== 1'b0 || MemStatus !== 2'b00) begin
            bad++;
            $display("FAIL after_done got done=%b busy=%b st=%b required 0 0 00", Done, Busy, MemStatus);
        end
    endtask

    task automatic test_reset;
        @(posedge CLK);
        #3 Reset = 1'b1;
        #1;
        total++;
        if (Busy !== 1'b0 || Done !== 1'b0 || RdData !== 16'h0 || MemStatus !== 2'b00 ||
            MemAddr !== 8'h00 || MemWrData !== 8'h00) begin
            bad++;
            $display("FAIL reset got busy=%b done=%b rd=%h st=%b a=%h d=%h required all zero",
                     Busy, Done, RdData, MemStatus, MemAddr, MemWrData);
        end
        exp_rd = 16'h0000;
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    task automatic test_idle;
        int errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (MemStatus !== 2'b00 || Done !== 1'b0 || Busy !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL idle got=%0d bad_cycles required=0", errs);
        end
    endtask

    task automatic test_directed;
        do_op(1'b1, 1'b0, 8'h10, 16'h00A5);
        do_op(1'b0, 1'b0, 8'h10, 16'h0000);
        total++;
        if (RdData !== 16'h00A5) begin bad++; $display("FAIL byte_load got=%h required=00a5", RdData); end
        do_op(1'b1, 1'b1, 8'h20, 16'hBEEF);
        total++;
        if (mem[8'h20] !== 8'hEF || mem[8'h21] !== 8'hBE) begin
            bad++; $display("FAIL wide_store got=%h%h required=beef", mem[8'h21], mem[8'h20]);
        end
        do_op(1'b0, 1'b1, 8'h20, 16'h0000);
        total++;
        if (RdData !== 16'hBEEF) begin bad++; $display("FAIL wide_load got=%h required=beef", RdData); end
        do_op(1'b1, 1'b1, 8'hFF, 16'h1234);
        total++;
        if (mem[8'hFF] !== 8'h34 || mem[8'h00] !== 8'h12) begin
            bad++; $display("FAIL wrap_store got=%h%h required=1234", mem[8'h00], mem[8'hFF]);
        end
        do_op(1'b0, 1'b1, 8'hFF, 16'h0000);
        total++;
        if (RdData !== 16'h1234) begin bad++; $display("FAIL wrap_load got=%h required=1234", RdData); end
        do_op(1'b0, 1'b0, 8'h20, 16'h0000);
        total++;
        if (RdData !== 16'h00EF) begin bad++; $display("FAIL byte_after_wide got=%h required=00ef", RdData); end
    endtask

    task automatic test_random;
        logic [7:0] a;
        for (int i = 0; i < 60; i++) begin
            a = (i % 4 == 0) ? 8'(8'hFE + 8'($urandom_range(0, 2))) : 8'($urandom);
            do_op(1'($urandom), 1'($urandom), a, 16'($urandom));
        end
        total++;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                $display("FAIL mem_compare addr=%h got=%h required=%h", i[7:0], mem[i], ref_mem[i]);
                break;
            end
        end
    endtask

    task automatic test_back_to_back(input bit wide);
        int         cyc = 0;
        int         last_done = -1;
        int         dones = 0;
        int         waitn = 0;
        logic [7:0] pend = 8'h00;
        logic [7:0] na;
        logic [7:0] p1;
        logic [15:0] e;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            cyc++;
            if (Done === 1'b1) begin
                dones++;
                p1 = pend + 8'd1;
                e = wide ? {ref_mem[p1], ref_mem[pend]} : {8'h00, ref_mem[pend]};
                total++;
                if (RdData !== e) begin
                    bad++; $display("FAIL b2b_rddata addr=%h got=%h required=%h", pend, RdData, e);
                end
                if (last_done >= 0) begin
                    total++;
                    if (cyc - last_done != (wide ? 4 : 3)) begin
                        bad++; $display("FAIL b2b_spacing got=%0d required=%0d", cyc - last_done, wide ? 4 : 3);
                    end
                end
                last_done = cyc;
                exp_rd = e;
            end
            na = 8'($urandom);
            if (Busy === 1'b0) pend = na;
            Req = 1'b1; Op = 1'b0; Wide = wide; Addr = na; WrData = 16'($urandom);
        end
        Req = 1'b0;
        total++;
        if (dones != (wide ? 10 : 13)) begin
            bad++; $display("FAIL b2b_count got=%0d required=%0d", dones, wide ? 10 : 13);
        end
        while (Busy === 1'b1 && waitn < 8) begin
            @(negedge CLK);
            waitn++;
        end
        total++;
        if (Busy !== 1'b0) begin bad++; $display("FAIL b2b_drain got busy=%b required=0", Busy); end
    endtask

    task automatic test_reset_mid;
        int   dseen = 0;
        logic [7:0] old41;
        old41 = mem[8'h41];
        @(negedge CLK);
        Req = 1'b1; Op = 1'b1; Wide = 1'b1; Addr = 8'h40; WrData = 16'hCAFE;
        @(posedge CLK);
        #1 Req = 1'b0;
        @(posedge CLK);
        #2 Reset = 1'b1;
        #1;
        total++;
        if (MemStatus !== 2'b00 || Busy !== 1'b0 || Done !== 1'b0 || RdData !== 16'h0000) begin
            bad++;
            $display("FAIL reset_mid got st=%b busy=%b done=%b rd=%h required 00 0 0 0000",
                     MemStatus, Busy, Done, RdData);
        end
        ref_mem[8'h40] = 8'hFE;
        exp_rd = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (i == 1) Reset = 1'b0;
            if (Done !== 1'b0) dseen++;
        end
        total++;
        if (dseen != 0) begin bad++; $display("FAIL reset_mid_done got=%0d pulses required=0", dseen); end
        total++;
        if (mem[8'h40] !== 8'hFE || mem[8'h41] !== old41) begin
            bad++;
            $display("FAIL reset_mid_mem got=%h/%h required=fe/%h", mem[8'h40], mem[8'h41], old41);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        Reset = 1'b1; Req = 1'b0; Op = 1'b0; Wide = 1'b0; Addr = '0; WrData = '0;
        exp_rd = 16'h0000;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        test_reset;
        test_idle;
        test_directed;
        test_random;
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_reset_mid;
        do_op(1'b0, 1'b1, 8'h40, 16'h0000);
        test_idle;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
